equiv_stream_aligner: RTL and testbench
=======================================

# equiv_stream_aligner

Output-alignment stage feeding the sequential-equivalence checkers. It captures the output streams of an original and an optimized implementation that may differ in latency, pairs the Nth sample of each, compares them, and presents aligned pairs plus match/mismatch status. Overflow, skew timeout, statistics and first-mismatch capture are reported for the formal and simulation benches.

## Interface
- DATA_WIDTH, 32, width of each output sample
- FIFO_DEPTH, 8, per-side buffer entries; power of two, ≥2
- TIMEOUT, 64, maximum cycles one side may lead without a pair forming; ≥1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- orig_valid  in  1  original implementation sample strobe (no backpressure)
- orig_data  in  DATA_WIDTH  original sample
- opt_valid  in  1  optimized implementation sample strobe (no backpressure)
- opt_data  in  DATA_WIDTH  optimized sample
- pair_valid  out  1  aligned pair presented this cycle (single-cycle pulse per pair)
- pair_orig  out  DATA_WIDTH  original sample of pair
- pair_opt  out  DATA_WIDTH  optimized sample of pair
- pair_match  out  1  pair_orig == pair_opt; qualified by pair_valid
- mismatch  out  1  sticky: any pair mismatched
- overflow  out  1  sticky: sample arrived at a full FIFO without a concurrent pop
- timeout  out  1  sticky: skew counter reached TIMEOUT
- match_count  out  32  saturating count of matched pairs
- mismatch_count  out  16  saturating count of mismatched pairs
- first_mis_idx  out  32  pair index (from 0) of first mismatch
- first_mis_orig, first_mis_opt  out  DATA_WIDTH each  data of first mismatch

## Operation
- Two FIFOs, one per side; a sample pushes when its valid is high.
- A pair pops from both FIFOs on any edge where both are non-empty in state ALIGNED or SKEW. Comparison is registered.
- Pair index is a 32-bit counter that increments per popped pair and wraps.
- Push onto a full FIFO:
  - Accepted if the same FIFO pops on that edge.
  - Otherwise the sample is dropped and overflow is set.
- States (from package enum):
  - ALIGNED: both FIFOs empty, or both non-empty.
  - SKEW: exactly one FIFO non-empty. Skew counter increments each cycle in SKEW and clears on leaving SKEW.
  - FAULT: entered from any state when overflow or timeout is set. Terminal until rst.
- In FAULT:
  - Both FIFOs flushed; inputs ignored; pair_valid held 0; counters and capture registers frozen.
  - Sticky flags hold.
- Timeout fires when the skew counter equals TIMEOUT. The transition to FAULT happens on that edge.
- Counters saturate at all-ones; no wrap.
- First mismatch: capture registers load on the first pair with pair_match=0 and never reload until rst.

## Timing
- Reset values: all outputs 0; state ALIGNED; FIFOs empty; skew counter 0; pair index 0.
- Latency: sample pushed at edge N (FIFO non-empty from N+1) → pop at edge N+1 if the partner is present → pair_valid high in cycle after edge N+1.
  - For the later-arriving sample, valid-in to pair_valid is 2 cycles.
- Simultaneous orig_valid and opt_valid into empty FIFOs: pair emerges 2 cycles later, state stays ALIGNED.
- Throughput: one pair per cycle sustained.
- mismatch, mismatch_count, and first_mis_* update in the same cycle pair_valid/pair_match=0 is visible.
- overflow visible the cycle after the dropped push edge; state FAULT from the same cycle.
- rst mid-stream: buffered samples discarded; the first post-reset pair has index 0.

## Configuration
- EQUIV_ALIGN_CAPTURE_EN defined:
  - first_mis_idx, first_mis_orig, and first_mis_opt are implemented as described.
- Undefined:
  - Capture registers are not built; those outputs are tied to 0.
  - mismatch and counters are unaffected.

## Structure
- Package equiv_align_pkg:
  - align_state_t enum (ALIGNED, SKEW, FAULT).
  - MATCH_CNT_W = 32, MISMATCH_CNT_W = 16, PAIR_IDX_W = 32.
- Sub-module equiv_sync_fifo is instantiated twice.
  - Parameters: DATA_WIDTH, FIFO_DEPTH.
  - Signals: push, pop, flush, full, empty, count; output data from the head.
- Top level holds the FSM, skew counter, comparator register, statistics, and capture.

## Test plan
- orig sample 0xA5 at cycle 0, opt sample 0xA5 at cycle 3 → pair_valid in cycle 5, pair_match=1, match_count=1, state SKEW during cycles 1–3.
- Streams 1,2,3 on both sides, opt lagging 2 cycles, opt third sample 0x7 instead of 3 → third pair has pair_match=0, mismatch=1, first_mis_idx=2, first_mis_orig=3, first_mis_opt=7, match_count=2.
- 9 orig samples, no opt samples (FIFO_DEPTH=8) → ninth sample dropped, overflow=1, state FAULT, pair_valid stays 0 thereafter.
- One orig sample, no opt, TIMEOUT=4 → timeout=1 after the skew counter reaches 4; later opt input produces no pair.
- 8 samples buffered on opt, then full-rate paired stream with orig → no overflow (simultaneous push/pop when full accepted), 1 pair/cycle.
- rst asserted with 3 samples buffered → all outputs 0 the next cycle; a new pair after reset reports index 0 and match_count=1.

Source files
------------

// File: rtl/equiv_align_pkg.sv
// rtl/equiv_align_pkg.sv - shared types and widths for the equivalence stream aligner
package equiv_align_pkg;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    SKEW    = 2'd1,
    FAULT   = 2'd2
  } align_state_t;

  localparam int MATCH_CNT_W    = 32;
  localparam int MISMATCH_CNT_W = 16;
  localparam int PAIR_IDX_W     = 32;

endpackage

// File: rtl/equiv_sync_fifo.sv
// rtl/equiv_sync_fifo.sv - single-clock FIFO with flush; head data always presented
module equiv_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees the slot on the same edge, so a push to a full FIFO is taken when it pops.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents beyond the pointers are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/equiv_stream_aligner.sv
// rtl/equiv_stream_aligner.sv - pairs original/optimized output streams and compares them (EQUIV_ALIGN_CAPTURE_EN enables first-mismatch capture)
module equiv_stream_aligner
  import equiv_align_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      orig_valid,
  input  logic [DATA_WIDTH-1:0]     orig_data,
  input  logic                      opt_valid,
  input  logic [DATA_WIDTH-1:0]     opt_data,
  output logic                      pair_valid,
  output logic [DATA_WIDTH-1:0]     pair_orig,
  output logic [DATA_WIDTH-1:0]     pair_opt,
  output logic                      pair_match,
  output logic                      mismatch,
  output logic                      overflow,
  output logic                      timeout,
  output logic [MATCH_CNT_W-1:0]    match_count,
  output logic [MISMATCH_CNT_W-1:0] mismatch_count,
  output logic [PAIR_IDX_W-1:0]     first_mis_idx,
  output logic [DATA_WIDTH-1:0]     first_mis_orig,
  output logic [DATA_WIDTH-1:0]     first_mis_opt
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int SKW = $clog2(TIMEOUT + 1);

  align_state_t state_q, state_d;
  logic [SKW-1:0] skew_cnt_q, skew_cnt_d;

  logic                  in_fault, pop;
  logic                  orig_push, opt_push, orig_acc, opt_acc;
  logic                  ovf_ev, timeout_ev, cmp_eq;
  logic [CW-1:0]         orig_count, opt_count, orig_nx, opt_nx;
  logic                  orig_full, orig_empty, opt_full, opt_empty;
  logic [DATA_WIDTH-1:0] orig_head, opt_head;

  logic                      pair_valid_q, pair_match_q, mismatch_q, overflow_q, timeout_q;
  logic [DATA_WIDTH-1:0]     pair_orig_q, pair_opt_q;
  logic [MATCH_CNT_W-1:0]    match_count_q;
  logic [MISMATCH_CNT_W-1:0] mismatch_count_q;
  logic [PAIR_IDX_W-1:0]     pair_idx_q;

  equiv_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_orig_fifo (
    .clk(clk), .rst(rst), .push(orig_push), .pop(pop), .flush(in_fault),
    .wdata(orig_data), .rdata(orig_head), .full(orig_full), .empty(orig_empty),
    .count(orig_count)
  );

  equiv_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_opt_fifo (
    .clk(clk), .rst(rst), .push(opt_push), .pop(pop), .flush(in_fault),
    .wdata(opt_data), .rdata(opt_head), .full(opt_full), .empty(opt_empty),
    .count(opt_count)
  );

  // Push/pop qualification and post-edge occupancy used to classify the next state.
  always_comb begin
    in_fault   = (state_q == FAULT);
    orig_push  = orig_valid && !in_fault;
    opt_push   = opt_valid && !in_fault;
    pop        = !orig_empty && !opt_empty && !in_fault;
    orig_acc   = orig_push && (!orig_full || pop);
    opt_acc    = opt_push && (!opt_full || pop);
    ovf_ev     = (orig_push && !orig_acc) || (opt_push && !opt_acc);
    timeout_ev = (state_q == SKEW) && (skew_cnt_q == SKW'(TIMEOUT));
    orig_nx    = orig_count + CW'(orig_acc) - CW'(pop);
    opt_nx     = opt_count + CW'(opt_acc) - CW'(pop);
    cmp_eq     = (orig_head == opt_head);
  end

  // Next-state and skew counter: FAULT is terminal; otherwise state mirrors FIFO occupancy.
  always_comb begin
    state_d    = state_q;
    skew_cnt_d = skew_cnt_q;
    unique case (state_q)
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        if (ovf_ev || timeout_ev) begin
          state_d = FAULT;
        end else if ((orig_nx != '0) != (opt_nx != '0)) begin
          state_d = SKEW;
        end else begin
          state_d = ALIGNED;
        end
        skew_cnt_d = (state_q == SKEW && state_d == SKEW) ? skew_cnt_q + SKW'(1) : '0;
      end
    endcase
  end

  // State and skew counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALIGNED;
      skew_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skew_cnt_q <= skew_cnt_d;
    end
  end

  // Registered comparison, sticky flags and saturating statistics; pop never occurs in FAULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_valid_q     <= 1'b0;
      pair_orig_q      <= '0;
      pair_opt_q       <= '0;
      pair_match_q     <= 1'b0;
      mismatch_q       <= 1'b0;
      overflow_q       <= 1'b0;
      timeout_q        <= 1'b0;
      match_count_q    <= '0;
      mismatch_count_q <= '0;
      pair_idx_q       <= '0;
    end else begin
      pair_valid_q <= pop;
      overflow_q   <= overflow_q | ovf_ev;
      timeout_q    <= timeout_q | timeout_ev;
      if (pop) begin
        pair_orig_q  <= orig_head;
        pair_opt_q   <= opt_head;
        pair_match_q <= cmp_eq;
        pair_idx_q   <= pair_idx_q + PAIR_IDX_W'(1);
        if (cmp_eq) begin
          if (match_count_q != '1) match_count_q <= match_count_q + MATCH_CNT_W'(1);
        end else begin
          mismatch_q <= 1'b1;
          if (mismatch_count_q != '1) mismatch_count_q <= mismatch_count_q + MISMATCH_CNT_W'(1);
        end
      end
    end
  end

`ifdef EQUIV_ALIGN_CAPTURE_EN
  logic                  cap_done_q;
  logic [PAIR_IDX_W-1:0] cap_idx_q;
  logic [DATA_WIDTH-1:0] cap_orig_q, cap_opt_q;

  // Load the capture registers once, on the first mismatched pair after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_done_q <= 1'b0;
      cap_idx_q  <= '0;
      cap_orig_q <= '0;
      cap_opt_q  <= '0;
    end else if (pop && !cmp_eq && !cap_done_q) begin
      cap_done_q <= 1'b1;
      cap_idx_q  <= pair_idx_q;
      cap_orig_q <= orig_head;
      cap_opt_q  <= opt_head;
    end
  end

  assign first_mis_idx  = cap_idx_q;
  assign first_mis_orig = cap_orig_q;
  assign first_mis_opt  = cap_opt_q;
`else
  logic unused_pair_idx;
  assign unused_pair_idx = ^pair_idx_q;
  assign first_mis_idx   = '0;
  assign first_mis_orig  = '0;
  assign first_mis_opt   = '0;
`endif

  assign pair_valid     = pair_valid_q;
  assign pair_orig      = pair_orig_q;
  assign pair_opt       = pair_opt_q;
  assign pair_match     = pair_match_q;
  assign mismatch       = mismatch_q;
  assign overflow       = overflow_q;
  assign timeout        = timeout_q;
  assign match_count    = match_count_q;
  assign mismatch_count = mismatch_count_q;

endmodule

// File: tb/tb_equiv_stream_aligner.sv
// tb/tb_equiv_stream_aligner.sv - directed self-checking bench for equiv_stream_aligner
module tb_equiv_stream_aligner;
  import equiv_align_pkg::*;

`ifdef EQUIV_ALIGN_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        orig_valid, opt_valid;
  logic [31:0] orig_data, opt_data;

  logic        pair_valid, pair_match, mismatch, overflow, timeout;
  logic [31:0] pair_orig, pair_opt, match_count, first_mis_idx, first_mis_orig, first_mis_opt;
  logic [15:0] mismatch_count;

  logic        t_pair_valid, t_pair_match, t_mismatch, t_overflow, t_timeout;
  logic [31:0] t_pair_orig, t_pair_opt, t_match_count, t_first_mis_idx, t_first_mis_orig, t_first_mis_opt;
  logic [15:0] t_mismatch_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  equiv_stream_aligner dut (
    .clk(clk), .rst(rst),
    .orig_valid(orig_valid), .orig_data(orig_data),
    .opt_valid(opt_valid), .opt_data(opt_data),
    .pair_valid(pair_valid), .pair_orig(pair_orig), .pair_opt(pair_opt),
    .pair_match(pair_match), .mismatch(mismatch), .overflow(overflow), .timeout(timeout),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .first_mis_idx(first_mis_idx), .first_mis_orig(first_mis_orig), .first_mis_opt(first_mis_opt)
  );

  equiv_stream_aligner #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst),
    .orig_valid(orig_valid), .orig_data(orig_data),
    .opt_valid(opt_valid), .opt_data(opt_data),
    .pair_valid(t_pair_valid), .pair_orig(t_pair_orig), .pair_opt(t_pair_opt),
    .pair_match(t_pair_match), .mismatch(t_mismatch), .overflow(t_overflow), .timeout(t_timeout),
    .match_count(t_match_count), .mismatch_count(t_mismatch_count),
    .first_mis_idx(t_first_mis_idx), .first_mis_orig(t_first_mis_orig), .first_mis_opt(t_first_mis_opt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ov, input logic [31:0] od, input logic pv, input logic [31:0] pd);
    orig_valid = ov;
    orig_data  = od;
    opt_valid  = pv;
    opt_data   = pd;
    tick();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    orig_valid = 1'b0;
    opt_valid  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; orig_valid = 1'b0; opt_valid = 1'b0; orig_data = '0; opt_data = '0;
    tick();
    do_reset();
    chk("rst_pair_valid", 32'(pair_valid), 32'd0);
    chk("rst_match_count", match_count, 32'd0);
    chk("rst_flags", {29'd0, mismatch, overflow, timeout}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ALIGNED));

    // orig leads by 3 cycles
    drive(1'b1, 32'hA5, 1'b0, 32'h0);
    chk("t1_state_c1", 32'(dut.state_q), 32'(SKEW));
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_state_c3", 32'(dut.state_q), 32'(SKEW));
    drive(1'b0, 32'h0, 1'b1, 32'hA5);
    chk("t1_state_c4", 32'(dut.state_q), 32'(ALIGNED));
    chk("t1_pv_c4", 32'(pair_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_pv_c5", 32'(pair_valid), 32'd1);
    chk("t1_match", 32'(pair_match), 32'd1);
    chk("t1_pair_orig", pair_orig, 32'hA5);
    chk("t1_match_count", match_count, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_pv_c6", 32'(pair_valid), 32'd0);

    // opt lags by 2, third opt sample corrupted
    do_reset();
    drive(1'b1, 32'd1, 1'b0, 32'd0);
    drive(1'b1, 32'd2, 1'b0, 32'd0);
    drive(1'b1, 32'd3, 1'b1, 32'd1);
    drive(1'b0, 32'd0, 1'b1, 32'd2);
    chk("t2_p0_valid", 32'(pair_valid), 32'd1);
    chk("t2_p0_orig", pair_orig, 32'd1);
    drive(1'b0, 32'd0, 1'b1, 32'd7);
    chk("t2_p1_opt", pair_opt, 32'd2);
    chk("t2_p1_match", 32'(pair_match), 32'd1);
    chk("t2_mis_before", 32'(mismatch), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t2_p2_valid", 32'(pair_valid), 32'd1);
    chk("t2_p2_match", 32'(pair_match), 32'd0);
    chk("t2_mismatch", 32'(mismatch), 32'd1);
    chk("t2_mis_count", 32'(mismatch_count), 32'd1);
    chk("t2_match_count", match_count, 32'd2);
    chk("t2_first_idx", first_mis_idx, CAP ? 32'd2 : 32'd0);
    chk("t2_first_orig", first_mis_orig, CAP ? 32'd3 : 32'd0);
    chk("t2_first_opt", first_mis_opt, CAP ? 32'd7 : 32'd0);

    // overflow: 9 orig samples into an 8-deep FIFO
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(i), 1'b0, 32'd0);
    chk("t3_ovf_at8", 32'(overflow), 32'd0);
    drive(1'b1, 32'd8, 1'b0, 32'd0);
    chk("t3_ovf_at9", 32'(overflow), 32'd1);
    chk("t3_state", 32'(dut.state_q), 32'(FAULT));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b1, 32'(i));
      chk("t3_pv_fault", 32'(pair_valid), 32'd0);
    end
    chk("t3_match_count", match_count, 32'd0);

    // timeout on the TIMEOUT=4 instance
    do_reset();
    drive(1'b1, 32'h11, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t4_timeout_c5", 32'(t_timeout), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t4_timeout_c6", 32'(t_timeout), 32'd1);
    chk("t4_state", 32'(dut_t.state_q), 32'(FAULT));
    chk("t4_default_no_timeout", 32'(timeout), 32'd0);
    drive(1'b0, 32'd0, 1'b1, 32'h11);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t4_pv_after", 32'(t_pair_valid), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t4_pv_after2", 32'(t_pair_valid), 32'd0);
    chk("t4_overflow", 32'(t_overflow), 32'd0);

    // opt pre-fills to full, then full-rate paired stream
    do_reset();
    for (int c = 0; c < 20; c++) begin
      logic        ov, pv, exp_pv;
      logic [31:0] od, pd;
      int          n;
      ov = (c >= 8 && c <= 16);
      od = 32'h10 + 32'(c - 8);
      pv = (c <= 7) || (c >= 9 && c <= 16);
      pd = (c <= 7) ? 32'h10 + 32'(c) : 32'h18 + 32'(c - 9);
      drive(ov, od, pv, pd);
      n = c + 1;
      exp_pv = (n >= 10 && n <= 18);
      chk($sformatf("t5_pv_c%0d", n), 32'(pair_valid), 32'(exp_pv));
      if (exp_pv) chk($sformatf("t5_orig_c%0d", n), pair_orig, 32'h10 + 32'(n - 10));
      chk($sformatf("t5_ovf_c%0d", n), 32'(overflow), 32'd0);
    end
    chk("t5_match_count", match_count, 32'd9);

    // one mismatching pair at index 9, then reset with opt samples still buffered
    drive(1'b1, 32'h99, 1'b0, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t6_pair_match", 32'(pair_match), 32'd0);
    chk("t6_first_idx", first_mis_idx, CAP ? 32'd9 : 32'd0);
    chk("t6_first_opt", first_mis_opt, CAP ? 32'h19 : 32'd0);
    orig_valid = 1'b1; orig_data = 32'h5;
    opt_valid  = 1'b1; opt_data  = 32'h6;
    rst = 1'b1;
    tick();
    rst = 1'b0; orig_valid = 1'b0; opt_valid = 1'b0;
    chk("t6_rst_mismatch", 32'(mismatch), 32'd0);
    chk("t6_rst_counts", match_count | 32'(mismatch_count), 32'd0);
    chk("t6_rst_pair", pair_orig | pair_opt | 32'(pair_valid) | 32'(pair_match), 32'd0);
    chk("t6_rst_first", first_mis_idx | first_mis_orig | first_mis_opt, 32'd0);
    chk("t6_rst_opt_fifo", 32'(dut.opt_count), 32'd0);
    chk("t6_rst_state", 32'(dut.state_q), 32'(ALIGNED));
    drive(1'b1, 32'h55, 1'b1, 32'h55);
    chk("t6_state_sim", 32'(dut.state_q), 32'(ALIGNED));
    chk("t6_idx_before", dut.pair_idx_q, 32'd0);
    chk("t6_pv_c1", 32'(pair_valid), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t6_pv_c2", 32'(pair_valid), 32'd1);
    chk("t6_orig", pair_orig, 32'h55);
    chk("t6_match_count", match_count, 32'd1);
    chk("t6_idx_after", dut.pair_idx_q, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
